// File: rtl/rand_pick_pkg.sv
// Shared constants and pick-outcome encoding for the random range picker.
// No logic; zero latency, no backpressure.
package rand_pick_pkg;

    localparam int LIMIT_DEFAULT     = 160;
    localparam int DEPTH_DEFAULT     = 4;
    localparam int MAX_TRIES_DEFAULT = 8;

    // Reject counter must hold MAX_TRIES-1 (up to 14); fill count must hold DEPTH (up to 8).
    localparam int REJ_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        PICK_IDLE     = 2'd0,
        PICK_ACCEPT   = 2'd1,
        PICK_REJECT   = 2'd2,
        PICK_FALLBACK = 2'd3
    } pick_e;

endpackage

// File: rtl/rand_pick_fifo.sv
// Prefetch buffer of picked bytes: a push is visible at the head one edge later.
// Push is ignored when full and pop when empty; flush empties the buffer.
module rand_pick_fifo
    import rand_pick_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [7:0]       i_push_dat,
    output logic [7:0]       o_head_dat,
    output logic [CNT_W-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_cnt == DEPTH_C);
    assign w_empty = (r_cnt == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_push  = i_push && !w_full && !i_flush;
    assign w_pop   = i_pop && !w_empty && !i_flush;

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_head_dat = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_count    = r_cnt;

endmodule

// File: rtl/rand_range_picker.sv
// Rejection-samples an LFSR byte into [0,LIMIT) with a mod fallback after MAX_TRIES misses; 1-cycle sample-to-output.
// Sampling stops while the buffer is full; RAND_PICK_NOREPEAT_EN also rejects repeats of the last pushed value.
module rand_range_picker
    import rand_pick_pkg::*;
#(
    parameter int LIMIT     = LIMIT_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int MAX_TRIES = MAX_TRIES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rnd_in,
    input  logic       flush,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [3:0] fill_level
);

    localparam logic [8:0]       LIMIT_C  = 9'(LIMIT);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(MAX_TRIES - 1);

    logic [REJ_W-1:0] r_rej;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_head;
    logic             w_sample;
    logic             w_in_range;
    logic             w_repeat;
    logic [7:0]       w_mod_dat;
    logic [7:0]       w_fb_dat;
    logic [7:0]       w_push_dat;
    logic             w_push;
    logic             w_pop;
    pick_e            w_pick;

    assign w_sample   = !reset && !flush && (w_count != DEPTH_C);
    assign w_in_range = ({1'b0, rnd_in} < LIMIT_C);
    assign w_mod_dat  = 8'({1'b0, rnd_in} % LIMIT_C);

`ifdef RAND_PICK_NOREPEAT_EN
    logic       r_last_vld;
    logic [7:0] r_last;
    logic [7:0] w_last_inc;

    assign w_repeat   = r_last_vld && (rnd_in == r_last);
    assign w_last_inc = (({1'b0, r_last} + 9'd1) == LIMIT_C) ? 8'h00 : (r_last + 8'd1);
    assign w_fb_dat   = (r_last_vld && (w_mod_dat == r_last)) ? w_last_inc : w_mod_dat;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_last_vld <= 1'b0;
            r_last     <= 8'h00;
        end else if (w_push) begin
            r_last_vld <= 1'b1;
            r_last     <= w_push_dat;
        end
    end
`else
    assign w_repeat = 1'b0;
    assign w_fb_dat = w_mod_dat;
`endif

    always_comb begin
        w_pick     = PICK_IDLE;
        w_push_dat = rnd_in;
        if (w_sample) begin
            if (w_in_range && !w_repeat) begin
                w_pick = PICK_ACCEPT;
            end else if (r_rej == REJ_LAST) begin
                w_pick     = PICK_FALLBACK;
                w_push_dat = w_fb_dat;
            end else begin
                w_pick = PICK_REJECT;
            end
        end
    end

    assign w_push = (w_pick == PICK_ACCEPT) || (w_pick == PICK_FALLBACK);
    assign w_pop  = out_ready && out_valid;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rej <= '0;
        end else begin
            case (w_pick)
                PICK_ACCEPT, PICK_FALLBACK: r_rej <= '0;
                PICK_REJECT:                r_rej <= r_rej + REJ_W'(1);
                default:                    r_rej <= r_rej;
            endcase
        end
    end

    rand_pick_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_flush    (flush),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_dat (w_push_dat),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign out_valid  = (w_count != '0);
    assign out_data   = w_head;
    assign fill_level = w_count;

endmodule

// File: tb/tb_rand_range_picker.sv
// Directed and randomized checks of rand_range_picker against a queue-based reference model.
module tb_rand_range_picker;

    localparam int LIMIT     = 160;
    localparam int DEPTH     = 4;
    localparam int MAX_TRIES = 8;
`ifdef RAND_PICK_NOREPEAT_EN
    localparam bit NR = 1'b1;
`else
    localparam bit NR = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rnd_in;
    logic       flush;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] fill_level;

    int compared = 0;
    int mismatched = 0;

    int m_q[$];
    int m_rej;
    int m_last;
    bit m_last_vld;

    always #5 clock = ~clock;

    rand_range_picker #(
        .LIMIT(LIMIT),
        .DEPTH(DEPTH),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rnd_in     (rnd_in),
        .flush      (flush),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_level (fill_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: what one rising edge does to the buffer contents.
    task automatic model_step();
        int v;
        bit do_pop;
        if (reset || flush) begin
            m_q.delete();
            m_rej = 0;
            m_last_vld = 1'b0;
            m_last = 0;
        end else begin
            do_pop = out_ready && (m_q.size() > 0);
            if (do_pop) void'(m_q.pop_front());
            if (m_q.size() + (do_pop ? 1 : 0) < DEPTH) begin
                v = -1;
                if (int'(rnd_in) < LIMIT && !(NR && m_last_vld && int'(rnd_in) == m_last)) begin
                    v = int'(rnd_in);
                end else if (m_rej + 1 == MAX_TRIES) begin
                    v = int'(rnd_in) % LIMIT;
                    if (NR && m_last_vld && v == m_last) v = (m_last + 1) % LIMIT;
                end else begin
                    m_rej++;
                end
                if (v >= 0) begin
                    m_q.push_back(v);
                    m_rej = 0;
                    m_last = v;
                    m_last_vld = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        chk("model_valid", {31'd0, out_valid}, (m_q.size() > 0) ? 32'd1 : 32'd0);
        chk("model_level", {28'd0, fill_level}, 32'(m_q.size()));
        chk("model_data", {24'd0, out_data}, (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    endtask

    initial begin
        m_rej = 0; m_last = 0; m_last_vld = 1'b0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; rnd_in = 8'h1F;
        cycle();
        cycle();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {24'd0, out_data}, 32'h00);
        chk("reset_level", {28'd0, fill_level}, 32'd0);

        // Constant in-range byte fills the buffer one entry per edge and then holds.
        reset = 1'b0;
        cycle();
        chk("fill_first_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_first_data", {24'd0, out_data}, 32'h1F);
        for (int k = 2; k <= 7; k++) begin
            cycle();
            chk("fill_level_ramp", {28'd0, fill_level}, (k < 4) ? 32'(k) : 32'd4);
        end

        // One pop while full: no push that cycle, refill on the next.
        out_ready = 1'b1;
        cycle();
        chk("full_pop_level", {28'd0, fill_level}, 32'd3);
        out_ready = 1'b0;
        cycle();
        chk("full_refill_level", {28'd0, fill_level}, 32'd4);
        cycle();
        chk("full_hold_level", {28'd0, fill_level}, 32'd4);

        // Reset with three entries buffered.
        rnd_in = 8'hF0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("pre_reset_level", {28'd0, fill_level}, 32'd3);
        reset = 1'b1;
        cycle();
        chk("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_reset_data", {24'd0, out_data}, 32'h00);
        chk("mid_reset_level", {28'd0, fill_level}, 32'd0);

        // Always-rejected byte: a fallback push of 240 mod 160 every 8 cycles.
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            chk("fallback_level", {28'd0, fill_level}, 32'(k / 8));
            if (k == 8) chk("fallback_value", {24'd0, out_data}, 32'h50);
        end

        // Flush beats a simultaneous accepted sample and pop.
        rnd_in = 8'h1F; out_ready = 1'b1; flush = 1'b1;
        cycle();
        chk("flush_level", {28'd0, fill_level}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; out_ready = 1'b0;
        cycle();
        chk("post_flush_level", {28'd0, fill_level}, 32'd1);

`ifdef RAND_PICK_NOREPEAT_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0; rnd_in = 8'h20; out_ready = 1'b1;
        cycle();
        chk("norep_first", {24'd0, out_data}, 32'h20);
        for (int k = 2; k <= 8; k++) begin
            cycle();
            chk("norep_reject_valid", {31'd0, out_valid}, 32'd0);
        end
        cycle();
        chk("norep_bump_valid", {31'd0, out_valid}, 32'd1);
        chk("norep_bump_data", {24'd0, out_data}, 32'h21);
`endif

        // Randomized traffic, including occasional flush and reset.
        for (int k = 0; k < 800; k++) begin
            rnd_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom);
            if ($urandom_range(0, 5) == 0) rnd_in = 8'hF7;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 120) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
